// File: rtl/hls_deadlock_monitor_gen_if.sv
// Signal bundle between a dataflow region's status taps and its deadlock monitor.
// The stall/idle/clear signals flow into the monitor; detection results flow out.
interface hls_deadlock_monitor_gen_if #(
    parameter int unsigned NUM_PROC = 4,
    parameter int unsigned NUM_AXIS = 1,
    parameter int unsigned CNT_W    = 16
);
    logic [NUM_AXIS-1:0] axis_block_sigs;
    logic [NUM_PROC-1:0] inst_idle_sigs;
    logic [NUM_PROC-1:0] inst_block_sigs;
    logic                clear;
    logic [NUM_AXIS-1:0] axis_block_info;
    logic                block;
    logic                block_sticky;
    logic [CNT_W-1:0]    block_count;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        input  axis_block_info, block, block_sticky, block_count
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        output axis_block_info, block, block_sticky, block_count
    );
endinterface

// File: rtl/hls_deadlock_monitor_gen.sv
// Deadlock monitor for one HLS dataflow region: flags a stable AXIS-involved stall in
// which no process can make progress, with sticky flag and saturating event count.
module hls_deadlock_monitor_gen #(
    parameter int unsigned                  NUM_PROC       = 4,
    parameter int unsigned                  NUM_AXIS       = 1,
    parameter logic [NUM_PROC*NUM_AXIS-1:0] PROC_AXIS_MASK = '1,
    parameter int unsigned                  STABLE_CYCLES  = 1,
    parameter int unsigned                  CNT_W          = 16
) (
    input logic                     clock,
    input logic                     reset,
    hls_deadlock_monitor_gen_if.slave mon_if
);
    localparam int unsigned StW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam logic [StW-1:0] StableMax = StW'(STABLE_CYCLES);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StArmed   = 2'd1;
    localparam logic [1:0] StBlocked = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [StW-1:0]      cnt_q, cnt_d;
    logic [NUM_AXIS-1:0] info_q, info_d;
    logic                sticky_q, sticky_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [NUM_PROC-1:0] proc_axis;
    logic [NUM_PROC-1:0] stop;
    logic [NUM_AXIS-1:0] axis_mask_or;
    logic                cand;
    logic                detect;

    always_comb begin
        axis_mask_or = '0;
        for (int p = 0; p < NUM_PROC; p++) begin
            proc_axis[p] = |(mon_if.axis_block_sigs & PROC_AXIS_MASK[p*NUM_AXIS +: NUM_AXIS]);
            stop[p]      = mon_if.inst_idle_sigs[p] | mon_if.inst_block_sigs[p] | proc_axis[p];
            axis_mask_or = axis_mask_or | PROC_AXIS_MASK[p*NUM_AXIS +: NUM_AXIS];
        end
        cand = (|proc_axis) & (&stop);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        detect  = 1'b0;
        case (state_q)
            StIdle: begin
                if (cand) begin
                    cnt_d = StW'(1);
                    if (STABLE_CYCLES == 1) begin
                        state_d = StBlocked;
                        detect  = 1'b1;
                    end else begin
                        state_d = StArmed;
                    end
                end
            end
            StArmed: begin
                if (!cand) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + StW'(1);
                    if (cnt_q + StW'(1) == StableMax) begin
                        state_d = StBlocked;
                        detect  = 1'b1;
                    end
                end
            end
            StBlocked: begin
                if (!cand) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Info is frozen at detection and only survives while BLOCKED persists.
        if (detect) begin
            info_d = mon_if.axis_block_sigs & axis_mask_or;
        end else if (state_d == StBlocked) begin
            info_d = info_q;
        end else begin
            info_d = '0;
        end

        // A detection outranks a coincident clear.
        sticky_d = sticky_q;
        count_d  = count_q;
        if (detect) begin
            sticky_d = 1'b1;
            if (mon_if.clear) begin
                count_d = CNT_W'(1);
            end else if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (mon_if.clear) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            info_q   <= '0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            info_q   <= info_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign mon_if.block           = (state_q == StBlocked);
    assign mon_if.axis_block_info = info_q;
    assign mon_if.block_sticky    = sticky_q;
    assign mon_if.block_count     = count_q;
endmodule

// File: tb/tb_hls_deadlock_monitor_gen.sv
// Bench for hls_deadlock_monitor_gen: four parameterisations, directed stimulus with
// hand-computed expectations queued per cycle and checked by an independent monitor.
module tb_hls_deadlock_monitor_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // A: defaults; B: STABLE_CYCLES=8; C: 3 procs x 2 channels; D: CNT_W=2.
    hls_deadlock_monitor_gen_if #(.NUM_PROC(4), .NUM_AXIS(1), .CNT_W(16)) ifa ();
    hls_deadlock_monitor_gen_if #(.NUM_PROC(4), .NUM_AXIS(1), .CNT_W(16)) ifb ();
    hls_deadlock_monitor_gen_if #(.NUM_PROC(3), .NUM_AXIS(2), .CNT_W(16)) ifc ();
    hls_deadlock_monitor_gen_if #(.NUM_PROC(4), .NUM_AXIS(1), .CNT_W(2))  ifd ();

    hls_deadlock_monitor_gen u_a (.clock(clk), .reset(rst), .mon_if(ifa.slave));
    hls_deadlock_monitor_gen #(.STABLE_CYCLES(8)) u_b (
        .clock(clk), .reset(rst), .mon_if(ifb.slave)
    );
    // ch0 -> procs 0,1; ch1 -> proc 2 only
    hls_deadlock_monitor_gen #(
        .NUM_PROC(3), .NUM_AXIS(2), .PROC_AXIS_MASK(6'b100101)
    ) u_c (.clock(clk), .reset(rst), .mon_if(ifc.slave));
    hls_deadlock_monitor_gen #(.CNT_W(2)) u_d (.clock(clk), .reset(rst), .mon_if(ifd.slave));

    typedef struct {
        int         d;
        logic [3:0] en;
        logic       b;
        logic [1:0] info;
        logic       s;
        int         cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int d, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %0d, expected %0d", name, d, $time, act, req);
        end
    endtask

    exp_t e;
    int   o_blk, o_info, o_stk, o_cnt;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            case (e.d)
                0: begin
                    o_blk = int'(ifa.block); o_info = int'(ifa.axis_block_info);
                    o_stk = int'(ifa.block_sticky); o_cnt = int'(ifa.block_count);
                end
                1: begin
                    o_blk = int'(ifb.block); o_info = int'(ifb.axis_block_info);
                    o_stk = int'(ifb.block_sticky); o_cnt = int'(ifb.block_count);
                end
                2: begin
                    o_blk = int'(ifc.block); o_info = int'(ifc.axis_block_info);
                    o_stk = int'(ifc.block_sticky); o_cnt = int'(ifc.block_count);
                end
                default: begin
                    o_blk = int'(ifd.block); o_info = int'(ifd.axis_block_info);
                    o_stk = int'(ifd.block_sticky); o_cnt = int'(ifd.block_count);
                end
            endcase
            if (e.en[3]) chk("block", e.d, o_blk, int'(e.b));
            if (e.en[2]) chk("axis_block_info", e.d, o_info, int'(e.info));
            if (e.en[1]) chk("block_sticky", e.d, o_stk, int'(e.s));
            if (e.en[0]) chk("block_count", e.d, o_cnt, e.cnt);
        end
    end

    task automatic drv(input int d, input logic [1:0] axis, input logic [3:0] idle,
                       input logic [3:0] blk, input logic clr);
        case (d)
            0: begin
                ifa.axis_block_sigs = axis[0:0]; ifa.inst_idle_sigs = idle;
                ifa.inst_block_sigs = blk; ifa.clear = clr;
            end
            1: begin
                ifb.axis_block_sigs = axis[0:0]; ifb.inst_idle_sigs = idle;
                ifb.inst_block_sigs = blk; ifb.clear = clr;
            end
            2: begin
                ifc.axis_block_sigs = axis; ifc.inst_idle_sigs = idle[2:0];
                ifc.inst_block_sigs = blk[2:0]; ifc.clear = clr;
            end
            default: begin
                ifd.axis_block_sigs = axis[0:0]; ifd.inst_idle_sigs = idle;
                ifd.inst_block_sigs = blk; ifd.clear = clr;
            end
        endcase
    endtask

    // Apply inputs for one cycle; queue what the outputs must show after the edge.
    task automatic step(input int d, input logic [1:0] axis, input logic [3:0] idle,
                        input logic [3:0] blk, input logic clr, input logic b,
                        input logic [1:0] info, input logic s, input int cnt);
        exp_t x;
        drv(d, axis, idle, blk, clr);
        @(posedge clk);
        x.d = d; x.en = 4'hF; x.b = b; x.info = info; x.s = s; x.cnt = cnt;
        q.push_back(x);
        #1;
    endtask

    // Single-channel DUTs: proc1 idle-less but AXIS-stalled => cand; axis=0 => no cand.
    task automatic on1(input int d, input logic clr, input logic b, input logic s,
                       input int cnt);
        step(d, 2'b01, 4'b1101, 4'b0000, clr, b, {1'b0, b}, s, cnt);
    endtask

    task automatic off1(input int d, input logic clr, input logic s, input int cnt);
        step(d, 2'b00, 4'b1101, 4'b0000, clr, 1'b0, 2'b00, s, cnt);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 4; d++) drv(d, 2'b00, 4'b0000, 4'b0000, 1'b0);
        for (int d = 0; d < 4; d++) step(d, 2'b00, 4'b0000, 4'b0000, 1'b0, 0, 2'b00, 0, 0);
        rst = 1'b0;

        // A: single-cycle latency, clear handling, reset while blocked.
        off1(0, 0, 0, 0);
        on1(0, 0, 1, 1, 1);
        on1(0, 0, 1, 1, 1);
        off1(0, 0, 1, 1);
        on1(0, 0, 1, 1, 2);
        off1(0, 0, 1, 2);
        off1(0, 1, 0, 0);
        on1(0, 0, 1, 1, 1);
        off1(0, 0, 1, 1);
        on1(0, 1, 1, 1, 1);
        on1(0, 1, 1, 0, 0);
        off1(0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            on1(0, 0, 1, 1, k);
            if (k < 5) off1(0, 0, 1, k);
        end
        rst = 1'b1;
        on1(0, 0, 0, 0, 0);
        rst = 1'b0;
        on1(0, 0, 1, 1, 1);

        // B: eight qualifying cycles, then a one-cycle dropout restarting qualification.
        for (int i = 1; i <= 8; i++) on1(1, 0, i == 8, i == 8, (i == 8) ? 1 : 0);
        off1(1, 0, 1, 1);
        for (int i = 1; i <= 4; i++) on1(1, 0, 0, 1, 1);
        off1(1, 0, 1, 1);
        for (int i = 1; i <= 8; i++) on1(1, 0, i == 8, 1, (i == 8) ? 2 : 1);

        // C: channel-to-process mask and per-channel info capture.
        step(2, 2'b10, 4'b0000, 4'b0011, 0, 1, 2'b10, 1, 1);
        step(2, 2'b10, 4'b0000, 4'b0001, 0, 0, 2'b00, 1, 1);
        step(2, 2'b10, 4'b0000, 4'b0001, 0, 0, 2'b00, 1, 1);
        step(2, 2'b01, 4'b0000, 4'b0100, 0, 1, 2'b01, 1, 2);
        step(2, 2'b11, 4'b0000, 4'b0100, 0, 1, 2'b01, 1, 2);
        step(2, 2'b00, 4'b0000, 4'b0100, 0, 0, 2'b00, 1, 2);

        // D: two-bit counter saturates at 3.
        for (int k = 1; k <= 5; k++) begin
            on1(3, 0, 1, 1, (k < 3) ? k : 3);
            off1(3, 0, 1, (k < 3) ? k : 3);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
